// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor with a valid/ready stream handshake.
// Each stage resolves WIDTH/BLOCK/STAGES look-ahead groups and forwards the running carry.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int unsigned NGRP = WIDTH / BLOCK;
  localparam int unsigned GPS  = NGRP / STAGES;
  localparam int unsigned BPS  = GPS * BLOCK;

  // Returns {carry into slice MSB, carry out of slice, slice sum bits}.
  // Carries inside a group are the flattened look-ahead products; groups chain.
  function automatic logic [BPS+1:0] cla_slice(input logic [BPS-1:0] fa,
                                              input logic [BPS-1:0] fb,
                                              input logic           fc);
    logic [BPS-1:0] p;
    logic [BPS-1:0] g;
    logic [BPS:0]   c;
    logic           ci;
    logic           pp;
    p    = fa ^ fb;
    g    = fa & fb;
    c    = '0;
    c[0] = fc;
    for (int k = 0; k < int'(GPS); k++) begin
      for (int i = 1; i <= int'(BLOCK); i++) begin
        ci = 1'b0;
        pp = 1'b1;
        for (int j = i - 1; j >= 0; j--) begin
          ci = ci | (g[k*int'(BLOCK) + j] & pp);
          pp = pp & p[k*int'(BLOCK) + j];
        end
        c[k*int'(BLOCK) + i] = ci | (pp & c[k*int'(BLOCK)]);
      end
    end
    return {c[BPS-1], c[BPS], p ^ c[BPS-1:0]};
  endfunction

  logic [WIDTH-1:0]  r_a     [STAGES];
  logic [WIDTH-1:0]  r_b     [STAGES];
  logic [WIDTH-1:0]  r_sum   [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_valid;
  logic              r_ovf;

  logic [WIDTH-1:0]  w_a     [STAGES];
  logic [WIDTH-1:0]  w_b     [STAGES];
  logic [WIDTH-1:0]  w_sum   [STAGES];
  logic [BPS+1:0]    w_slice [STAGES];
  logic [STAGES-1:0] w_c;
  logic [STAGES-1:0] w_v;
  logic              w_adv;

  // Global stall: the whole pipe advances only when the output slot frees up.
  assign out_valid = r_valid[STAGES-1];
  assign in_ready  = ~out_valid | out_ready;
  assign w_adv     = in_ready;
  assign sum       = r_sum[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign ovf       = r_ovf;

  for (genvar s = 0; s < int'(STAGES); s++) begin : g_stage
    localparam int unsigned      LO   = s * BPS;
    localparam logic [WIDTH-1:0] MASK = WIDTH'({BPS{1'b1}}) << LO;

    if (s == 0) begin : g_src
      assign w_v[s]   = in_valid;
      assign w_a[s]   = a;
      assign w_b[s]   = b ^ {WIDTH{sub}};
      assign w_sum[s] = '0;
      assign w_c[s]   = sub | cin;
    end else begin : g_src
      assign w_v[s]   = r_valid[s-1];
      assign w_a[s]   = r_a[s-1];
      assign w_b[s]   = r_b[s-1];
      assign w_sum[s] = r_sum[s-1];
      assign w_c[s]   = r_c[s-1];
    end

    assign w_slice[s] = cla_slice(w_a[s][LO +: BPS], w_b[s][LO +: BPS], w_c[s]);

    // Data only loads for real beats so the output holds the last result across bubbles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid[s] <= 1'b0;
        r_a[s]     <= '0;
        r_b[s]     <= '0;
        r_sum[s]   <= '0;
        r_c[s]     <= 1'b0;
      end else if (w_adv) begin
        r_valid[s] <= w_v[s];
        if (w_v[s]) begin
          r_a[s]   <= w_a[s];
          r_b[s]   <= w_b[s];
          r_sum[s] <= (w_sum[s] & ~MASK) | (WIDTH'(w_slice[s][BPS-1:0]) << LO);
          r_c[s]   <= w_slice[s][BPS];
        end
      end
    end

    if (s == int'(STAGES) - 1) begin : g_ovf
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_adv && w_v[s]) begin
          r_ovf <= w_slice[s][BPS+1] ^ w_slice[s][BPS];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: directed corner beats, backpressure,
// mid-stream reset and a random stream scored against an arithmetic reference model.
module tb_pipelined_cla_adder;
  localparam int unsigned W   = 16;
  localparam int unsigned BLK = 4;
  localparam int unsigned STG = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int           n_cmp = 0;
  int           n_err = 0;
  int           n_out = 0;
  int           n_in  = 0;
  logic [W+1:0] exp_q [$];
  logic         hold_pend = 1'b0;
  logic [W+1:0] held;
  logic         last_in_fire;
  logic [W-1:0] pa;
  logic [W-1:0] pb;
  logic         pc;
  logic         ps;
  logic         pending;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(W), .BLOCK(BLK), .STAGES(STG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {cout, ovf, sum} from plain integer arithmetic on the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
    longint ua, ub, u, sa, sb, sr, two_w, half;
    logic   co, ov;
    two_w = longint'(1) << W;
    half  = longint'(1) << (W - 1);
    ua = longint'(ma);
    ub = longint'(mb);
    if (ms) u = ua + (two_w - ub);
    else    u = ua + ub + longint'(mc);
    co = (u >= two_w);
    sa = ma[W-1] ? ua - two_w : ua;
    sb = mb[W-1] ? ub - two_w : ub;
    sr = ms ? sa - sb : sa + sb + longint'(mc);
    ov = (sr >= half) || (sr < -half);
    return {co, ov, W'(u)};
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  // One clock: drive, score at negedge, then return #1 after the next rising edge.
  task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic ic, input logic is, input logic ior);
    in_valid = iv; a = ia; b = ib; cin = ic; sub = is; out_ready = ior;
    @(negedge clk);
    if (hold_pend) check("hold", 64'({out_valid, cout, ovf, sum}), 64'({1'b1, held}));
    hold_pend = out_valid && !out_ready;
    held      = {cout, ovf, sum};
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        check("result", 64'({cout, ovf, sum}), 64'(exp_q.pop_front()));
        n_out++;
      end
    end
    last_in_fire = in_valid && in_ready;
    if (last_in_fire) begin
      exp_q.push_back(model(ia, ib, ic, is));
      n_in++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int i, guard, n0, n1;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_state", 64'({out_valid, cout, ovf, sum}), 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rdy_after_rst", 64'(in_ready), 64'd1);

    // Carry wrap and exact two-cycle latency.
    step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    check("lat_early", 64'(out_valid), 64'd0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("wrap", 64'({cout, ovf, sum}), 64'({1'b1, 1'b0, 16'h0000}));
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // Signed overflow both ways and subtract with borrow, back to back.
    step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    check("ovf_add", 64'({cout, ovf, sum}), 64'({1'b0, 1'b1, 16'h8000}));
    step(1'b1, 16'h0003, 16'h0005, 1'b1, 1'b1, 1'b1);
    check("ovf_sub", 64'({cout, ovf, sum}), 64'({1'b1, 1'b1, 16'h7FFF}));
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("borrow", 64'({cout, ovf, sum}), 64'({1'b0, 1'b0, 16'hFFFE}));
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("bubble_out", 64'(out_valid), 64'd0);

    // Backpressure with 8 beats a=b=i, cin=1.
    n0 = n_out; i = 0; guard = 0;
    while ((i < 8 || exp_q.size() != 0) && guard < 200) begin
      if (i < 8) step(1'b1, W'(i), W'(i), 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      else       step(1'b0, '0, '0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      if (last_in_fire) i++;
      guard++;
    end
    check("bp_drain", 64'(exp_q.size()), 64'd0);
    check("bp_count", 64'(n_out - n0), 64'd8);

    // Random stream with bubbles and random stalls.
    n0 = n_out; n1 = n_in; pending = 1'b0;
    pa = '0; pb = '0; pc = 1'b0; ps = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (!pending) begin
        pa = rnd_op(); pb = rnd_op();
        pc = 1'($urandom_range(0, 1)); ps = 1'($urandom_range(0, 1));
        pending = ($urandom_range(0, 3) != 0);
      end
      step(pending, pa, pb, pc, ps, ($urandom_range(0, 3) != 0));
      if (last_in_fire) pending = 1'b0;
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    check("rand_drain", 64'(exp_q.size()), 64'd0);
    check("rand_count", 64'(n_out - n0), 64'(n_in - n1));

    // Reset with two beats in flight; they must never emerge.
    step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_async", 64'({out_valid, sum}), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_hold", 64'({out_valid, sum}), 64'd0);
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    exp_q.delete();
    hold_pend = 1'b0;
    repeat (4) begin
      step(1'b0, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b1);
      check("post_rst", 64'({out_valid, sum}), 64'd0);
    end
    step(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("post_rst_beat", 64'({out_valid, cout, ovf, sum}), 64'({1'b1, 1'b0, 1'b0, 16'h5556}));
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("post_rst_drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
